// File: rtl/parking_pkg.sv
// Shared definitions for the parking_gate_array car-park controller.
// Contents:
//   gate_state_t - per-gate state encoding
//   CNT_W        - width of the occupancy and free-space counts
//   seg7         - digit to active-low gfedcba seven-segment pattern
//   bcd_split    - 0..99 value to {tens, units} BCD digits
package parking_pkg;

    localparam int CNT_W = 7;

    typedef enum logic [2:0] {
        GATE_IDLE       = 3'd0,
        GATE_WAIT_PASS  = 3'd1,
        GATE_ENTRY_OPEN = 3'd2,
        GATE_EXIT_OPEN  = 3'd3,
        GATE_LOCKED     = 3'd4
    } gate_state_t;

    // Active-low gfedcba. A non-decimal input blanks the digit.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Returns {tens, units}. The input never exceeds 99, so the tens digit fits in 4 bits.
    function automatic logic [7:0] bcd_split(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] tens;
        logic [CNT_W-1:0] units;
        tens  = value / 7'd10;
        units = value % 7'd10;
        return {tens[3:0], units[3:0]};
    endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// One gate of the car park: entry with password check, retry lockout, timed barrier and exit.
// Ports:
//   clk, rst                  - clock, synchronous active-low reset
//   sensor_entry, sensor_exit - car present at the entry / exit of this gate
//   password, pw_valid        - submitted password and its one-cycle strobe
//   full                      - car park full (from the shared occupancy register)
//   entry_grant, exit_grant   - same-cycle answers from the shared arbiter
//   entry_req, exit_req       - requests to move a car in / out this cycle
//   green, red                - lamp drives decoded from the state register
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter int                  PW_WIDTH    = 16,
    parameter logic [PW_WIDTH-1:0] PASSWORD    = 16'h1234,
    parameter int                  MAX_TRIES   = 3,
    parameter int                  OPEN_CYCLES = 50,
    parameter int                  LOCK_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sensor_entry,
    input  logic                sensor_exit,
    input  logic [PW_WIDTH-1:0] password,
    input  logic                pw_valid,
    input  logic                full,
    input  logic                entry_grant,
    input  logic                exit_grant,
    output logic                entry_req,
    output logic                exit_req,
    output logic                green,
    output logic                red
);

    localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]       TRY_LIMIT = 4'(MAX_TRIES);

    gate_state_t      state_r, state_s;
    logic [3:0]       tries_r, tries_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic             pw_match_s;

    assign pw_match_s = (password == PASSWORD);

    // Requests are kept apart from next-state logic so the grant path has no combinational loop.
    always_comb begin
        entry_req = 1'b0;
        exit_req  = 1'b0;
        if (state_r == GATE_WAIT_PASS) begin
            entry_req = sensor_entry && pw_valid && pw_match_s;
        end else if (state_r == GATE_IDLE) begin
            // Entry wins over exit at the same gate; a full park turns entry away so exit may proceed.
            exit_req = !(sensor_entry && !full) && sensor_exit;
        end else begin
            entry_req = 1'b0;
            exit_req  = 1'b0;
        end
    end

    // Next-state, retry counter and barrier/lockout timer.
    always_comb begin
        state_s = state_r;
        tries_s = tries_r;
        timer_s = timer_r;
        case (state_r)
            GATE_IDLE: begin
                timer_s = '0;
                if (sensor_entry && !full) begin
                    state_s = GATE_WAIT_PASS;
                end else if (exit_req && exit_grant) begin
                    state_s = GATE_EXIT_OPEN;
                end else begin
                    state_s = GATE_IDLE;
                end
            end
            GATE_WAIT_PASS: begin
                if (!sensor_entry) begin
                    state_s = GATE_IDLE;
                    tries_s = 4'd0;
                end else if (pw_valid && pw_match_s) begin
                    if (entry_grant) begin
                        state_s = GATE_ENTRY_OPEN;
                        tries_s = 4'd0;
                        timer_s = '0;
                    end else begin
                        // Lost the last space to a lower-index gate: retries are kept.
                        state_s = GATE_IDLE;
                    end
                end else if (pw_valid) begin
                    tries_s = tries_r + 4'd1;
                    if ((tries_r + 4'd1) >= TRY_LIMIT) begin
                        state_s = GATE_LOCKED;
                        timer_s = '0;
                    end else begin
                        state_s = GATE_WAIT_PASS;
                    end
                end else begin
                    state_s = GATE_WAIT_PASS;
                end
            end
            GATE_ENTRY_OPEN, GATE_EXIT_OPEN: begin
                if (timer_r == OPEN_LAST) begin
                    state_s = GATE_IDLE;
                    timer_s = '0;
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
            GATE_LOCKED: begin
                if (timer_r == LOCK_LAST) begin
                    state_s = GATE_IDLE;
                    tries_s = 4'd0;
                    timer_s = '0;
                end else begin
                    timer_s = timer_r + 1'b1;
                end
            end
            default: begin
                state_s = GATE_IDLE;
                tries_s = 4'd0;
                timer_s = '0;
            end
        endcase
    end

    // State, retry and timer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= GATE_IDLE;
            tries_r <= 4'd0;
            timer_r <= '0;
        end else begin
            state_r <= state_s;
            tries_r <= tries_s;
            timer_r <= timer_s;
        end
    end

    assign green = (state_r == GATE_ENTRY_OPEN) || (state_r == GATE_EXIT_OPEN);
    assign red   = ((state_r == GATE_IDLE) && full) ||
                   (state_r == GATE_WAIT_PASS) || (state_r == GATE_LOCKED);

endmodule

// File: rtl/parking_gate_array.sv
// Multi-gate car-park controller: NUM_GATES gate FSMs share one occupancy counter.
// The arbiter works on the current count and serves the lowest gate index first.
// Ports:
//   clk, rst                  - clock, synchronous active-low reset
//   sensor_entry, sensor_exit - per-gate car-present sensors
//   password, pw_valid        - per-gate keypad word (gate g at [g*PW_WIDTH +: PW_WIDTH]) and strobe
//   green, red                - per-gate lamps
//   full, occupancy           - park-full flag and current car count
//   HEX_1, HEX_2              - free spaces tens / units, active-low gfedcba, one cycle behind occupancy
//   HEX_3, HEX_4              - occupancy tens / units, active-low gfedcba, one cycle behind occupancy
module parking_gate_array
    import parking_pkg::*;
#(
    parameter int                  NUM_GATES   = 2,
    parameter int                  CAPACITY    = 99,
    parameter int                  PW_WIDTH    = 16,
    parameter logic [PW_WIDTH-1:0] PASSWORD    = 16'h1234,
    parameter int                  MAX_TRIES   = 3,
    parameter int                  OPEN_CYCLES = 50,
    parameter int                  LOCK_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_GATES-1:0]          sensor_entry,
    input  logic [NUM_GATES-1:0]          sensor_exit,
    input  logic [NUM_GATES*PW_WIDTH-1:0] password,
    input  logic [NUM_GATES-1:0]          pw_valid,
    output logic [NUM_GATES-1:0]          green,
    output logic [NUM_GATES-1:0]          red,
    output logic                          full,
    output logic [CNT_W-1:0]              occupancy,
    output logic [6:0]                    HEX_1,
    output logic [6:0]                    HEX_2,
    output logic [6:0]                    HEX_3,
    output logic [6:0]                    HEX_4
);

    localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAPACITY);
    localparam logic [7:0]       CAP_BCD = bcd_split(CAP_C);

    logic [CNT_W-1:0]     occupancy_r, occupancy_s;
    logic [CNT_W-1:0]     free_s;
    logic [CNT_W-1:0]     exit_cnt_s, entry_cnt_s;
    logic [NUM_GATES-1:0] entry_req_s, exit_req_s;
    logic [NUM_GATES-1:0] entry_grant_s, exit_grant_s;
    logic                 full_s;
    logic [7:0]           free_bcd_s, occ_bcd_s;

    assign free_s     = CAP_C - occupancy_r;
    assign full_s     = (occupancy_r == CAP_C);
    assign free_bcd_s = bcd_split(free_s);
    assign occ_bcd_s  = bcd_split(occupancy_r);

    for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
        parking_gate_fsm #(
            .PW_WIDTH    (PW_WIDTH),
            .PASSWORD    (PASSWORD),
            .MAX_TRIES   (MAX_TRIES),
            .OPEN_CYCLES (OPEN_CYCLES),
            .LOCK_CYCLES (LOCK_CYCLES)
        ) u_fsm (
            .clk          (clk),
            .rst          (rst),
            .sensor_entry (sensor_entry[g]),
            .sensor_exit  (sensor_exit[g]),
            .password     (password[g*PW_WIDTH +: PW_WIDTH]),
            .pw_valid     (pw_valid[g]),
            .full         (full_s),
            .entry_grant  (entry_grant_s[g]),
            .exit_grant   (exit_grant_s[g]),
            .entry_req    (entry_req_s[g]),
            .exit_req     (exit_req_s[g]),
            .green        (green[g]),
            .red          (red[g])
        );
    end

    // Fixed-priority arbiter: exits bounded by current occupancy, entries by current free space.
    always_comb begin
        exit_cnt_s    = '0;
        entry_cnt_s   = '0;
        exit_grant_s  = '0;
        entry_grant_s = '0;
        for (int g = 0; g < NUM_GATES; g++) begin
            if (exit_req_s[g] && (exit_cnt_s < occupancy_r)) begin
                exit_grant_s[g] = 1'b1;
                exit_cnt_s      = exit_cnt_s + 7'd1;
            end else begin
                exit_grant_s[g] = 1'b0;
            end
            if (entry_req_s[g] && (entry_cnt_s < free_s)) begin
                entry_grant_s[g] = 1'b1;
                entry_cnt_s      = entry_cnt_s + 7'd1;
            end else begin
                entry_grant_s[g] = 1'b0;
            end
        end
        // Both counts are bounded above, so this stays within 0..CAPACITY.
        occupancy_s = occupancy_r - exit_cnt_s + entry_cnt_s;
    end

    // Occupancy register and display digits (digits follow the registered count).
    always_ff @(posedge clk) begin
        if (!rst) begin
            occupancy_r <= '0;
            HEX_1       <= seg7(CAP_BCD[7:4]);
            HEX_2       <= seg7(CAP_BCD[3:0]);
            HEX_3       <= seg7(4'd0);
            HEX_4       <= seg7(4'd0);
        end else begin
            occupancy_r <= occupancy_s;
            HEX_1       <= seg7(free_bcd_s[7:4]);
            HEX_2       <= seg7(free_bcd_s[3:0]);
            HEX_3       <= seg7(occ_bcd_s[7:4]);
            HEX_4       <= seg7(occ_bcd_s[3:0]);
        end
    end

    assign full      = full_s;
    assign occupancy = occupancy_r;

endmodule

// File: doc/parking_gate_array.md
# parking_gate_array

Parametrised multi-gate car-park controller: NUM_GATES independent gate state machines (entry with password check, retry lockout, timed barrier, exit) sharing one saturating occupancy counter with fixed-priority arbitration. Drives per-gate green/red lamps, a full flag, and four registered active-low seven-segment digits showing free spaces and occupancy. It is the next generation of the two-gate car_parking controller and sits between the gate sensor/keypad front-ends and the lobby display.

## Interface
- NUM_GATES, 2, number of gates (1..8)
- CAPACITY, 99, maximum cars (1..99)
- PW_WIDTH, 16, password width
- PASSWORD, 16'h1234, accepted password (PW_WIDTH bits)
- MAX_TRIES, 3, wrong attempts before lockout (1..15)
- OPEN_CYCLES, 50, barrier-open duration in clocks (≥1)
- LOCK_CYCLES, 1000, lockout duration in clocks (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- sensor_entry  in  NUM_GATES  car present at entry of gate g
- sensor_exit  in  NUM_GATES  car present at exit of gate g
- password  in  NUM_GATES*PW_WIDTH  gate g uses bits [g*PW_WIDTH +: PW_WIDTH]
- pw_valid  in  NUM_GATES  one-cycle strobe: password of gate g is submitted
- green  out  NUM_GATES  barrier open
- red  out  NUM_GATES  waiting / refused / locked / full
- full  out  1  occupancy == CAPACITY
- occupancy  out  7  current car count
- HEX_1, HEX_2  out  7 each  free spaces tens / units, active-low gfedcba
- HEX_3, HEX_4  out  7 each  occupancy tens / units, active-low gfedcba

## Operation
- Per-gate states: IDLE, WAIT_PASS, ENTRY_OPEN, EXIT_OPEN, LOCKED. Each gate has a retry counter and a timer.
- IDLE (green=0; red=full): sensor_entry & ~full → WAIT_PASS; else sensor_exit → exit request; entry has priority over exit at the same gate. Exit request granted → EXIT_OPEN; not granted → stay IDLE.
- WAIT_PASS (red=1): sensor_entry low → IDLE, tries cleared. pw_valid with match → entry request; granted → ENTRY_OPEN, tries cleared; not granted (capacity exhausted) → IDLE, tries unchanged. pw_valid with mismatch → tries+1; if tries reaches MAX_TRIES → LOCKED.
- ENTRY_OPEN / EXIT_OPEN (green=1, red=0): timer counts OPEN_CYCLES clocks, then IDLE. Sensors and pw_valid ignored.
- LOCKED (red=1): ignores all inputs for LOCK_CYCLES clocks, then IDLE with tries=0.
- Arbitration per cycle, on the current count: exit grants limited to occupancy, entry grants limited to CAPACITY−occupancy, each assigned lowest gate index first. occupancy_next = occupancy − exit_grants + entry_grants; never below 0 or above CAPACITY.
- full is combinational from the occupancy register.
- Display: free = CAPACITY−occupancy, split into tens/units (÷10), encoded to seven-segment (0 → 7'b1000000).
- Reset: all gates IDLE, tries=0, timers=0, occupancy=0, green=0, red=0, full=0, HEX_1/HEX_2 = digits of CAPACITY, HEX_3/HEX_4 = "0".

## Timing
- All state, counters and HEX registers update on posedge clk; rst is sampled only on the edge.
- Password to lamp: pw_valid at edge N → green=1 and occupancy updated after edge N (visible cycle N+1).
- green stays high for exactly OPEN_CYCLES cycles. LOCKED lasts exactly LOCK_CYCLES cycles.
- HEX outputs lag occupancy by one cycle.
- rst low mid-operation aborts open barriers, lockouts and retry counts next edge; occupancy returns to 0.

## Structure
- Package parking_pkg: gate-state enum, seven-segment encode function, BCD split function, 7-bit count width constant.
- Sub-module parking_gate_fsm: one instance per gate via generate. It holds the state, tries and timer, and raises entry_req/exit_req. The top level holds the arbiter, occupancy register and display registers.

## Test plan
- Reset then gate 0 entry with 16'h1234 and pw_valid → green[0]=1 next cycle for 50 cycles; occupancy 0→1; HEX_2 shows 8 (free 98), HEX_4 shows 1.
- Gate 0 submits 16'h1111 three times → red[0]=1, LOCKED; a correct password during lockout is ignored; IDLE after 1000 cycles.
- CAPACITY=1, gates 0 and 1 both submit a correct password in the same cycle → only green[0]; gate 1 returns to IDLE; full=1.
- occupancy=1, exit on gate 1 and correct entry on gate 0 in the same cycle → both green; occupancy stays 1.
- occupancy=0, sensor_exit[0]=1 → no green, occupancy stays 0.
- rst low during ENTRY_OPEN → green=0, occupancy=0, HEX_1..HEX_4 at reset values after one edge.
